draw_glyph_overlay: RTL and testbench

Parametrised glyph-strip overlay for the VGA pipeline. It draws a row of `N_COLS` glyphs at 2 bits per pixel, fetched row by row from an external glyph ROM, with integer pixel scaling and a 3-colour palette; code `00` is transparent. The strip position can be moved at run time through a valid/ready handshake and takes effect only at frame boundaries. It sits between two `vga_if` stages, like the other `draw_*` blocks, and delays all timing signals to match its own latency.

---
 rtl/draw_glyph_overlay_if.sv | 20 ++
 rtl/draw_glyph_overlay.sv | 237 +++++++++++++++++++++++
 tb/tb_draw_glyph_overlay.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_glyph_overlay_if.sv
// ---------------------------------------------------------------------------
// vga_if: timing and colour bundle passed between the draw_* pipeline stages.
//   vcount/hcount : current pixel coordinates (11 bits each)
//   vsync/hsync   : sync pulses, carried unchanged by every stage
//   vblnk/hblnk   : blanking flags; a stage never draws while either is set
//   rgb           : 12-bit colour, 4 bits per channel
// Modport 'in' is the consumer side; modport 'out' is the producer side.
// ---------------------------------------------------------------------------
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_glyph_overlay.sv
// ---------------------------------------------------------------------------
// draw_glyph_overlay
//
// Draws a horizontal strip of N_COLS glyphs (2 bits per pixel, code 00 is
// transparent) on top of the incoming VGA stream. Glyph rows are fetched from
// an external ROM, and every source pixel is replicated SCALE times in x and y.
// The strip origin can be moved at run time through a valid/ready handshake;
// a new origin is only adopted on the rising edge of vga_in.vblnk, so a single
// frame is always drawn at a single position.
//
// Ports
//   clk, rst      : pixel clock, synchronous active-high reset
//   vga_in        : upstream timing + rgb
//   vga_out       : downstream timing + rgb, delayed by ROM_LAT+2 cycles
//   glyph_addr    : registered ROM address {col, row}
//   glyph_pixels  : ROM row returned ROM_LAT cycles after glyph_addr;
//                   the most significant bit pair is the leftmost pixel
//   pos_x, pos_y  : requested strip origin
//   pos_valid     : origin request valid
//   pos_ready     : low while a request waits for the next frame boundary
//
// Build option
//   GLYPH_BLINK_EN : adds a 6-bit frame counter; the overlay is hidden while
//                    counter bit 5 is set (32 frames on, 32 frames off).
// ---------------------------------------------------------------------------
module draw_glyph_overlay #(
    parameter int          GLYPH_W = 32,
    parameter int          GLYPH_H = 32,
    parameter int          SCALE   = 2,
    parameter int          N_COLS  = 8,
    parameter int          ROM_LAT = 1,
    parameter int          POS_X0  = 64,
    parameter int          POS_Y0  = 64,
    parameter logic [11:0] COL1    = 12'h666,
    parameter logic [11:0] COL2    = 12'hfff,
    parameter logic [11:0] COL3    = 12'h000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    vga_if.in                                         vga_in,
    vga_if.out                                        vga_out,
    output logic [$clog2(N_COLS)+$clog2(GLYPH_H)-1:0] glyph_addr,
    input  logic [2*GLYPH_W-1:0]                      glyph_pixels,
    input  logic [10:0]                               pos_x,
    input  logic [10:0]                               pos_y,
    input  logic                                      pos_valid,
    output logic                                      pos_ready
);

    localparam int COL_W  = $clog2(N_COLS);
    localparam int ROW_W  = $clog2(GLYPH_H);
    localparam int ADDR_W = COL_W + ROW_W;
    localparam int PX_W   = $clog2(GLYPH_W);
    localparam int SC_SH  = $clog2(SCALE);
    localparam int COL_SH = $clog2(GLYPH_W * SCALE);
    localparam int DEPTH  = ROM_LAT + 1;

    // Region extents, kept at 12 bits so origin + extent never wraps.
    localparam logic [11:0] STRIP_W = 12'(N_COLS * GLYPH_W * SCALE);
    localparam logic [11:0] STRIP_H = 12'(GLYPH_H * SCALE);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t            vga;
        logic            in_region;
        logic [PX_W-1:0] px;
    } pipe_t;

    // Position handshake state.
    logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [10:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d;
    logic        pending_q, pending_d;
    logic        vblnk_prev_q, vblnk_prev_d;
    logic        frame_boundary;

    // Stage 0 and the delay line.
    vga_t              vga_in_s;
    logic              in_region;
    logic              draw_en;
    logic [10:0]       dx, dy;
    logic [ADDR_W-1:0] glyph_addr_q, glyph_addr_d;
    pipe_t             pipe_q [DEPTH];
    pipe_t             pipe_d [DEPTH];

    // Output stage.
    pipe_t             pipe_tail;
    logic [1:0]        code;
    vga_t              out_q, out_d;

    assign vga_in_s = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                        hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                        hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                        rgb:    vga_in.rgb};

    assign pos_ready = !pending_q;

`ifdef GLYPH_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_boundary) frame_cnt_d = frame_cnt_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    // Gated at stage 0 together with the position, so a frame is either
    // fully drawn or fully passed through.
    assign draw_en = !frame_cnt_q[5];
`else
    assign draw_en = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Position handshake. A transfer needs pending_q low and a swap needs it
    // high, so the two can never collide: a request taken on the boundary
    // cycle waits for the following boundary.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        act_x_d        = act_x_q;
        act_y_d        = act_y_q;
        shd_x_d        = shd_x_q;
        shd_y_d        = shd_y_q;
        pending_d      = pending_q;
        vblnk_prev_d   = vga_in.vblnk;
        frame_boundary = vga_in.vblnk && !vblnk_prev_q;

        if (frame_boundary && pending_q) begin
            act_x_d   = shd_x_q;
            act_y_d   = shd_y_q;
            pending_d = 1'b0;
        end

        if (pos_valid && pos_ready) begin
            shd_x_d   = pos_x;
            shd_y_d   = pos_y;
            pending_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: region test and ROM address. dx/dy are only meaningful inside
    // the region; outside it the address is held so the ROM stays quiet.
    // -----------------------------------------------------------------------
    always_comb begin
        in_region = ({1'b0, vga_in.hcount} >= {1'b0, act_x_q}) &&
                    ({1'b0, vga_in.hcount} <  ({1'b0, act_x_q} + STRIP_W)) &&
                    ({1'b0, vga_in.vcount} >= {1'b0, act_y_q}) &&
                    ({1'b0, vga_in.vcount} <  ({1'b0, act_y_q} + STRIP_H));

        dx = vga_in.hcount - act_x_q;
        dy = vga_in.vcount - act_y_q;

        glyph_addr_d = glyph_addr_q;
        if (in_region) glyph_addr_d = {COL_W'(dx >> COL_SH), ROW_W'(dy >> SC_SH)};

        pipe_d[0].vga       = vga_in_s;
        pipe_d[0].in_region = in_region && draw_en;
        pipe_d[0].px        = PX_W'(dx >> SC_SH);
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // -----------------------------------------------------------------------
    // Output stage: the ROM row arrives exactly as the matching pixel leaves
    // the delay line; pick its 2-bit code and map it through the palette.
    // -----------------------------------------------------------------------
    assign pipe_tail = pipe_q[DEPTH-1];

    always_comb begin
        code  = 2'(glyph_pixels >> (2 * (GLYPH_W - 1 - int'(pipe_tail.px))));
        out_d = pipe_tail.vga;
        if (pipe_tail.in_region && !pipe_tail.vga.hblnk && !pipe_tail.vga.vblnk) begin
            case (code)
                2'b01:   out_d.rgb = COL1;
                2'b10:   out_d.rgb = COL2;
                2'b11:   out_d.rgb = COL3;
                default: out_d.rgb = pipe_tail.vga.rgb;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every _q register samples the
        // pre-edge value of every other register regardless of statement order.
        if (rst) begin
            act_x_q      <= 11'(POS_X0);
            act_y_q      <= 11'(POS_Y0);
            shd_x_q      <= 11'(POS_X0);
            shd_y_q      <= 11'(POS_Y0);
            pending_q    <= 1'b0;
            vblnk_prev_q <= 1'b0;
            glyph_addr_q <= '0;
            // NOTE: the delay line is a short chain of flops rather than a
            // RAM, so it is cleared with everything else and vga_out reads 0
            // until genuine pixels have travelled through it.
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
            out_q        <= '0;
        end else begin
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            shd_x_q      <= shd_x_d;
            shd_y_q      <= shd_y_d;
            pending_q    <= pending_d;
            vblnk_prev_q <= vblnk_prev_d;
            glyph_addr_q <= glyph_addr_d;
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
            out_q        <= out_d;
        end
    end

    assign glyph_addr     = glyph_addr_q;
    assign vga_out.hcount = out_q.hcount;
    assign vga_out.vcount = out_q.vcount;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_glyph_overlay.sv
// ---------------------------------------------------------------------------
// Testbench for draw_glyph_overlay. A driver issues one pixel per cycle and
// pushes the expected output pixel and ROM address, computed from plain
// integer arithmetic on the strip geometry, into queues; a monitor pops and
// compares them as the DUT produces its outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_draw_glyph_overlay;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 32;
    localparam int SCALE   = 2;
    localparam int N_COLS  = 8;
    localparam int ROM_LAT = 1;
    localparam int POS_X0  = 64;
    localparam int POS_Y0  = 64;
    localparam int LAT     = ROM_LAT + 2;
    localparam int STRIP_W = N_COLS * GLYPH_W * SCALE;
    localparam int STRIP_H = GLYPH_H * SCALE;
    localparam logic [11:0] C1 = 12'h666;
    localparam logic [11:0] C2 = 12'hfff;
    localparam logic [11:0] C3 = 12'h000;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  glyph_addr;
    logic [63:0] glyph_pixels;
    logic [10:0] pos_x = '0;
    logic [10:0] pos_y = '0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;

    vga_if vif_in ();
    vga_if vif_out ();

    always #5 clk = ~clk;

    draw_glyph_overlay #(
        .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .SCALE(SCALE), .N_COLS(N_COLS),
        .ROM_LAT(ROM_LAT), .POS_X0(POS_X0), .POS_Y0(POS_Y0),
        .COL1(C1), .COL2(C2), .COL3(C3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga_in(vif_in),
        .vga_out(vif_out),
        .glyph_addr(glyph_addr),
        .glyph_pixels(glyph_pixels),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .pos_valid(pos_valid),
        .pos_ready(pos_ready)
    );

    // ROM model with ROM_LAT cycles of read latency.
    logic [63:0] rom_mem  [256];
    logic [63:0] rom_pipe [ROM_LAT];

    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[glyph_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign glyph_pixels = rom_pipe[ROM_LAT-1];

    // Scoreboard and reference state.
    int   checks = 0;
    int   errors = 0;
    vga_t exp_q[$];
    int   addr_q[$];
    int   req_x[$];
    int   req_y[$];

    int m_x, m_y, m_sx, m_sy, m_addr, m_frames;
    bit m_pending, m_prev_vb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit overlay_off();
`ifdef GLYPH_BLINK_EN
        return ((m_frames / 32) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // One pixel per call: drives the inputs and records what must come out.
    task automatic drive(input int h, input int v, input bit hb, input bit vb);
        vga_t        e;
        bit          inr, ready_now, boundary, fire;
        int          dx, dy, col, row, px, code;
        logic [63:0] w;
        logic [11:0] rgb;

        @(posedge clk); #1;
        ready_now = !m_pending;
        check("pos_ready", 64'(pos_ready), 64'(ready_now));

        pos_valid = (req_x.size() != 0);
        if (pos_valid) begin
            pos_x = 11'(req_x[0]);
            pos_y = 11'(req_y[0]);
        end
        fire = pos_valid && pos_ready;

        rgb = 12'($urandom);
        vif_in.hcount = 11'(h);
        vif_in.vcount = 11'(v);
        vif_in.hblnk  = hb;
        vif_in.vblnk  = vb;
        vif_in.hsync  = 1'($urandom);
        vif_in.vsync  = 1'($urandom);
        vif_in.rgb    = rgb;

        e = '{hcount: 11'(h), vcount: 11'(v), hsync: vif_in.hsync, vsync: vif_in.vsync,
              hblnk: hb, vblnk: vb, rgb: rgb};

        inr = (h >= m_x) && (h < m_x + STRIP_W) && (v >= m_y) && (v < m_y + STRIP_H);
        if (inr) begin
            dx     = h - m_x;
            dy     = v - m_y;
            col    = dx / (GLYPH_W * SCALE);
            row    = dy / SCALE;
            px     = (dx / SCALE) % GLYPH_W;
            m_addr = col * GLYPH_H + row;
            w      = rom_mem[m_addr];
            code   = int'(w[2*(GLYPH_W-1-px) +: 2]);
            if (!hb && !vb && !overlay_off()) begin
                if (code == 1) e.rgb = C1;
                if (code == 2) e.rgb = C2;
                if (code == 3) e.rgb = C3;
            end
        end
        exp_q.push_back(e);
        addr_q.push_back(m_addr);

        boundary  = vb && !m_prev_vb;
        m_prev_vb = vb;
        if (boundary) begin
            if (m_pending) begin
                m_x       = m_sx;
                m_y       = m_sy;
                m_pending = 1'b0;
            end
            m_frames++;
        end
        if (pos_valid && ready_now) begin
            m_sx      = req_x[0];
            m_sy      = req_y[0];
            m_pending = 1'b1;
        end
        if (fire) begin
            void'(req_x.pop_front());
            void'(req_y.pop_front());
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        pos_valid     = 1'b0;
        vif_in.hcount = '0;
        vif_in.vcount = '0;
        vif_in.hsync  = 1'b0;
        vif_in.vsync  = 1'b0;
        vif_in.hblnk  = 1'b0;
        vif_in.vblnk  = 1'b0;
        vif_in.rgb    = '0;
        exp_q.delete();
        addr_q.delete();
        req_x.delete();
        req_y.delete();
        repeat (cycles) @(posedge clk);
        #1;
        check("reset_vga_out", 64'({vif_out.hcount, vif_out.vcount, vif_out.hsync, vif_out.vsync,
                                    vif_out.hblnk, vif_out.vblnk, vif_out.rgb}), 64'd0);
        check("reset_glyph_addr", 64'(glyph_addr), 64'd0);
        check("reset_pos_ready", 64'(pos_ready), 64'd1);
        m_x = POS_X0; m_y = POS_Y0; m_sx = POS_X0; m_sy = POS_Y0;
        m_pending = 1'b0; m_prev_vb = 1'b0; m_addr = 0; m_frames = 0;
        rst = 1'b0;
    endtask

    // Pixels scattered around the current strip, then a short vertical blank.
    task automatic rand_frame(input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            int h, v;
            h = m_x - 8 + int'($urandom_range(0, STRIP_W + 16));
            v = m_y - 4 + int'($urandom_range(0, STRIP_H + 8));
            if ($urandom_range(0, 9) == 0) h = int'($urandom_range(0, 2047));
            if (h > 2047) h = 2047;
            if (h < 0) h = 0;
            if (v > 2047) v = 2047;
            if (v < 0) v = 0;
            drive(h, v, $urandom_range(0, 7) == 0, 1'b0);
        end
        for (int i = 0; i < 4; i++)
            drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b1, 1'b1);
    endtask

    // Monitor: pops expectations once the DUT latency has elapsed.
    initial begin
        vga_t e, got;
        int   a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > LAT) begin
                e   = exp_q.pop_front();
                got = '{hcount: vif_out.hcount, vcount: vif_out.vcount, hsync: vif_out.hsync,
                        vsync: vif_out.vsync, hblnk: vif_out.hblnk, vblnk: vif_out.vblnk,
                        rgb: vif_out.rgb};
                check("vga_out", 64'(got), 64'(e));
            end
            if (addr_q.size() > 1) begin
                a = addr_q.pop_front();
                check("glyph_addr", 64'(glyph_addr), 64'(a));
            end
        end
    end

    initial begin
        vif_in.hcount = '0;
        vif_in.vcount = '0;
        vif_in.hsync  = 1'b0;
        vif_in.vsync  = 1'b0;
        vif_in.hblnk  = 1'b0;
        vif_in.vblnk  = 1'b0;
        vif_in.rgb    = '0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 64'h4000_0000_0000_0000;

        do_reset(3);

        // Default origin, single code-01 pixel at the left of every glyph row.
        drive(64, 64, 1'b0, 1'b0);
        drive(65, 64, 1'b0, 1'b0);
        drive(66, 64, 1'b0, 1'b0);
        drive(63, 64, 1'b0, 1'b0);
        drive(576, 64, 1'b0, 1'b0);
        drive(575, 64, 1'b0, 1'b0);
        drive(128, 70, 1'b0, 1'b0);
        drive(575, 127, 1'b0, 1'b0);
        drive(100, 128, 1'b0, 1'b0);
        drive(100, 63, 1'b0, 1'b0);
        drive(64, 64, 1'b1, 1'b0);
        repeat (4) drive(0, 0, 1'b0, 1'b0);

        // Codes 10 and 11 at pixel 1, then fully random glyph content.
        for (int i = 0; i < 256; i++)
            rom_mem[i] = (i % 2 == 0) ? 64'h6000_0000_0000_0000 : 64'h7000_0000_0000_0000;
        drive(66, 64, 1'b0, 1'b0);
        drive(67, 64, 1'b0, 1'b0);
        drive(66, 66, 1'b0, 1'b0);
        drive(67, 66, 1'b0, 1'b0);
        drive(63, 64, 1'b0, 1'b0);
        drive(576, 64, 1'b0, 1'b0);
        repeat (4) drive(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) rom_mem[i] = {$urandom, $urandom};
        rand_frame(200);

        // Origin change requested mid-frame, second request held off.
        req_x.push_back(100); req_y.push_back(200);
        req_x.push_back(0);   req_y.push_back(0);
        rand_frame(60);
        drive(99, 200, 1'b0, 1'b0);
        drive(100, 200, 1'b0, 1'b0);
        drive(100, 199, 1'b0, 1'b0);
        drive(611, 263, 1'b0, 1'b0);
        drive(612, 263, 1'b0, 1'b0);
        drive(611, 264, 1'b0, 1'b0);
        rand_frame(80);
        rand_frame(80);

        // Strip near the right edge must clip, not wrap into low hcounts.
        req_x.push_back(1900); req_y.push_back(70);
        rand_frame(40);
        rand_frame(80);
        for (int h = 0; h <= 100; h += 10) drive(h, 80, 1'b0, 1'b0);
        drive(2047, 80, 1'b0, 1'b0);
        drive(1900, 70, 1'b0, 1'b0);
        rand_frame(40);

        // Reset mid-frame with a request outstanding.
        req_x.push_back(300); req_y.push_back(300);
        repeat (5) drive(400, 100, 1'b0, 1'b0);
        do_reset(2);
        rand_frame(100);
        rand_frame(100);

        // Long randomized run with occasional moves (also spans blink periods).
        for (int f = 0; f < 70; f++) begin
            if ($urandom_range(0, 3) == 0 && req_x.size() == 0) begin
                req_x.push_back(int'($urandom_range(0, 2047)));
                req_y.push_back(int'($urandom_range(0, 2047)));
            end
            rand_frame(110);
        end

        repeat (LAT + 2) drive(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
